// File: rtl/multi_channel_clock_divider.sv
// N-channel programmable clock divider with shadowed, boundary-applied divisors.
// Optional DIVIDER_DUTY_EN adds div_high for independent high/low phase counts.
module multi_channel_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    inclk,
  input  logic                    Reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] div_count,
`ifdef DIVIDER_DUTY_EN
  input  logic [NUM_CH*CNT_W-1:0] div_high,
`endif
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       div_busy,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       outclk_Not,
  output logic [NUM_CH-1:0]       edge_tick
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] act_lo;
    logic [CNT_W-1:0] act_hi;
    logic [CNT_W-1:0] shd_lo;
    logic [CNT_W-1:0] shd_hi;
    logic [CNT_W-1:0] new_lo;
    logic [CNT_W-1:0] new_hi;
    logic [CNT_W-1:0] limit;
    logic             pending;
    logic             clk_q;
    logic             nclk_q;
    logic             tick_q;
    logic             toggle;
    logic             apply;

    assign new_lo = div_count[i*CNT_W +: CNT_W];
`ifdef DIVIDER_DUTY_EN
    assign new_hi = div_high[i*CNT_W +: CNT_W];
`else
    assign new_hi = new_lo;
`endif

    // outclk high means we are timing the high phase
    assign limit  = clk_q ? act_hi : act_lo;
    assign toggle = ch_en[i] && (counter >= limit);
    assign apply  = pending && (!ch_en[i] || (toggle && clk_q));

    always_ff @(posedge inclk) begin
      if (Reset) begin
        counter <= '0;
        act_lo  <= '0;
        act_hi  <= '0;
        shd_lo  <= '0;
        shd_hi  <= '0;
        pending <= 1'b0;
        clk_q   <= 1'b0;
        nclk_q  <= 1'b1;
        tick_q  <= 1'b0;
      end else begin
        if (apply) begin
          act_lo <= shd_lo;
          act_hi <= shd_hi;
        end
        // a load coinciding with apply keeps pending set
        if (div_load[i]) begin
          shd_lo  <= new_lo;
          shd_hi  <= new_hi;
          pending <= 1'b1;
        end else if (apply) begin
          pending <= 1'b0;
        end
        if (!ch_en[i]) begin
          counter <= '0;
          clk_q   <= 1'b0;
          nclk_q  <= 1'b1;
          tick_q  <= 1'b0;
        end else if (toggle) begin
          counter <= '0;
          clk_q   <= ~clk_q;
          nclk_q  <= clk_q;
          tick_q  <= 1'b1;
        end else begin
          counter <= counter + 1'b1;
          tick_q  <= 1'b0;
        end
      end
    end

    assign div_busy[i]   = pending;
    assign outclk[i]     = clk_q;
    assign outclk_Not[i] = nclk_q;
    assign edge_tick[i]  = tick_q;
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench for multi_channel_clock_divider: vector table, directed corners,
// and random traffic against a phase-length reference model.
module tb_multi_channel_clock_divider;
  localparam int N = 4;
  localparam int W = 32;

  logic         inclk = 1'b0;
  logic         Reset;
  logic [N-1:0] ch_en;
  logic [N-1:0] div_load;
  logic [N*W-1:0] div_count;
`ifdef DIVIDER_DUTY_EN
  logic [N*W-1:0] div_high;
`endif
  logic [N-1:0] div_busy;
  logic [N-1:0] outclk;
  logic [N-1:0] outclk_Not;
  logic [N-1:0] edge_tick;

  always #5 inclk = ~inclk;

  multi_channel_clock_divider #(.NUM_CH(N), .CNT_W(W)) dut (
    .inclk      (inclk),
    .Reset      (Reset),
    .ch_en      (ch_en),
    .div_count  (div_count),
`ifdef DIVIDER_DUTY_EN
    .div_high   (div_high),
`endif
    .div_load   (div_load),
    .div_busy   (div_busy),
    .outclk     (outclk),
    .outclk_Not (outclk_Not),
    .edge_tick  (edge_tick)
  );

  int checks = 0;
  int errors = 0;

  // model: phase lengths in cycles, countdown to next toggle
  bit          m_clk [N];
  bit          m_tick[N];
  bit          m_busy[N];
  int unsigned m_lo  [N];
  int unsigned m_hi  [N];
  int unsigned s_lo  [N];
  int unsigned s_hi  [N];
  int unsigned m_left[N];

  typedef struct {
    bit          rst;
    bit          en;
    bit          ld;
    int unsigned cnt;
    bit          e_clk;
    bit          e_tick;
    bit          e_busy;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(string nm, int c, logic a, logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s ch%0d: got %b expected %b", nm, c, a, e);
    end
  endtask

  task automatic chk_int(string nm, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic set_div(int c, int unsigned lo, int unsigned hi);
    div_count[c*W +: W] = lo;
`ifdef DIVIDER_DUTY_EN
    div_high[c*W +: W] = hi;
`else
    if (hi != lo) $display("note: high count ignored in symmetric build");
`endif
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit ap;
      if (Reset) begin
        m_clk[c]  = 0;
        m_tick[c] = 0;
        m_busy[c] = 0;
        m_lo[c]   = 0;
        m_hi[c]   = 0;
        s_lo[c]   = 0;
        s_hi[c]   = 0;
        m_left[c] = 1;
      end else begin
        ap = m_busy[c] && (!ch_en[c] || (m_left[c] == 1 && m_clk[c]));
        if (ap) begin
          m_lo[c] = s_lo[c];
          m_hi[c] = s_hi[c];
        end
        if (!ch_en[c]) begin
          m_clk[c]  = 0;
          m_tick[c] = 0;
          m_left[c] = m_lo[c] + 1;
        end else if (m_left[c] == 1) begin
          m_clk[c]  = !m_clk[c];
          m_tick[c] = 1;
          m_left[c] = m_clk[c] ? m_hi[c] + 1 : m_lo[c] + 1;
        end else begin
          m_left[c] = m_left[c] - 1;
          m_tick[c] = 0;
        end
        if (div_load[c]) begin
          s_lo[c] = div_count[c*W +: W];
`ifdef DIVIDER_DUTY_EN
          s_hi[c] = div_high[c*W +: W];
`else
          s_hi[c] = div_count[c*W +: W];
`endif
          m_busy[c] = 1;
        end else if (ap) begin
          m_busy[c] = 0;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge inclk);
    #1;
    for (int c = 0; c < N; c++) begin
      chk("outclk", c, outclk[c], m_clk[c]);
      chk("outclk_Not", c, outclk_Not[c], !m_clk[c]);
      chk("edge_tick", c, edge_tick[c], m_tick[c]);
      chk("div_busy", c, div_busy[c], m_busy[c]);
    end
    div_load = '0;
  endtask

  task automatic wait_edge(int c, logic lvl, int budget, output int n);
    logic prev;
    n = 0;
    for (int k = 0; k < budget; k++) begin
      prev = outclk[c];
      step();
      n++;
      if (prev != lvl && outclk[c] == lvl) return;
    end
    checks++;
    errors++;
    $display("FAIL edge_timeout ch%0d: got no edge, required edge to %b in %0d", c, lvl, budget);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    int n;
    int nt;
    Reset     = 1'b1;
    ch_en     = '0;
    div_load  = '0;
    div_count = '0;
`ifdef DIVIDER_DUTY_EN
    div_high  = '0;
`endif

    tbl[0] = '{1, 1, 1, 9, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 4, 0, 0, 1};
    tbl[4] = '{0, 0, 0, 0, 0, 0, 0};
    for (int i = 5; i < 9; i++) tbl[i] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[9] = '{0, 1, 0, 0, 1, 1, 0};
    for (int i = 10; i < 14; i++) tbl[i] = '{0, 1, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 1, 0};
    for (int i = 15; i < 19; i++) tbl[i] = '{0, 1, 0, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 0, 0, 1, 1, 0};

    for (int i = 0; i < 20; i++) begin
      Reset       = tbl[i].rst;
      ch_en[0]    = tbl[i].en;
      div_load[0] = tbl[i].ld;
      set_div(0, tbl[i].cnt, tbl[i].cnt);
      step();
      chk("tbl_outclk", 0, outclk[0], tbl[i].e_clk);
      chk("tbl_tick", 0, edge_tick[0], tbl[i].e_tick);
      chk("tbl_busy", 0, div_busy[0], tbl[i].e_busy);
    end

    // ch0 steady at 4: period 10, two ticks per period
    wait_edge(0, 1, 40, n);
    chk_int("ch0_period", n, 10);
    nt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      nt += int'(edge_tick[0]);
    end
    chk_int("ch0_ticks", nt, 2);

    // ch1 at 9, retarget to 2 mid high phase
    set_div(1, 9, 9);
    div_load[1] = 1'b1;
    step();
    step();
    ch_en[1] = 1'b1;
    wait_edge(1, 1, 40, n);
    chk_int("ch1_first_rise", n, 10);
    repeat (3) step();
    set_div(1, 2, 2);
    div_load[1] = 1'b1;
    step();
    chk("ch1_busy_set", 1, div_busy[1], 1'b1);
    wait_edge(1, 0, 40, n);
    chk_int("ch1_old_high", n + 4, 10);
    chk("ch1_busy_clr", 1, div_busy[1], 1'b0);
    wait_edge(1, 1, 40, n);
    chk_int("ch1_new_low", n, 3);
    wait_edge(1, 1, 40, n);
    chk_int("ch1_new_period", n, 6);

    // ch2 double load, then load on the apply cycle
    set_div(2, 5, 5);
    div_load[2] = 1'b1;
    step();
    step();
    ch_en[2] = 1'b1;
    wait_edge(2, 1, 40, n);
    set_div(2, 7, 7);
    div_load[2] = 1'b1;
    step();
    set_div(2, 3, 3);
    div_load[2] = 1'b1;
    step();
    wait_edge(2, 0, 40, n);
    wait_edge(2, 1, 40, n);
    chk_int("ch2_last_wins", n, 4);
    set_div(2, 1, 1);
    div_load[2] = 1'b1;
    step();
    step();
    step();
    set_div(2, 5, 5);
    div_load[2] = 1'b1;
    step();
    chk("ch2_apply_fall", 2, outclk[2], 1'b0);
    chk("ch2_busy_kept", 2, div_busy[2], 1'b1);
    wait_edge(2, 1, 40, n);
    chk_int("ch2_low_1", n, 2);
    wait_edge(2, 0, 40, n);
    chk_int("ch2_high_1", n, 2);
    chk("ch2_busy_done", 2, div_busy[2], 1'b0);
    wait_edge(2, 1, 40, n);
    chk_int("ch2_low_5", n, 6);

    // ch3 disable while high, then re-enable
    set_div(3, 3, 3);
    div_load[3] = 1'b1;
    step();
    step();
    ch_en[3] = 1'b1;
    wait_edge(3, 1, 40, n);
    step();
    ch_en[3] = 1'b0;
    step();
    chk("ch3_dis_low", 3, outclk[3], 1'b0);
    chk("ch3_dis_tick", 3, edge_tick[3], 1'b0);
    chk("ch3_dis_not", 3, outclk_Not[3], 1'b1);
    step();
    ch_en[3] = 1'b1;
    wait_edge(3, 1, 40, n);
    chk_int("ch3_reenable", n, 4);

`ifdef DIVIDER_DUTY_EN
    ch_en[3] = 1'b0;
    set_div(3, 5, 1);
    div_load[3] = 1'b1;
    step();
    step();
    ch_en[3] = 1'b1;
    wait_edge(3, 1, 40, n);
    chk_int("duty_first_low", n, 6);
    wait_edge(3, 0, 40, n);
    chk_int("duty_high", n, 2);
    wait_edge(3, 1, 40, n);
    chk_int("duty_low", n, 6);
`endif

    // random traffic against the model
    for (int k = 0; k < 2000; k++) begin
      Reset = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 29) == 0) ch_en[c] = ~ch_en[c];
        if ($urandom_range(0, 7) == 0) begin
          div_load[c] = 1'b1;
          set_div(c, $urandom_range(0, 6), $urandom_range(0, 6));
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
